// File: rtl/router_sync.sv
// Clocked N_IN -> N_OUT channel router with per-channel valid strobes and a
// double-buffered (shadow/active) source table committed on a rising update edge.
module router_sync #(
    parameter int unsigned W_CHAN    = 16,
    parameter int unsigned W_SEL     = 4,
    parameter int unsigned N_IN      = 8,
    parameter int unsigned N_OUT     = 8,
    parameter bit          ACTV_INIT = 1'b1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [W_CHAN*N_IN-1:0]    data_packed_in,
    input  logic [N_IN-1:0]           data_valid_in,
    input  logic [W_SEL-1:0]          src_select_in,
    input  logic [W_SEL-1:0]          dest_select_in,
    input  logic                      active_in,
    input  logic                      hold_in,
    input  logic                      wr_en_in,
    input  logic                      update_in,
    output logic [W_CHAN*N_OUT-1:0]   data_packed_out,
    output logic [N_OUT-1:0]          data_valid_out,
    output logic                      commit_ack_out
);

    typedef struct packed {
        logic [W_SEL-1:0] src;
        logic             active;
        logic             hold;
    } entry_t;

    localparam entry_t ENTRY_RST = '{src: '0, active: ACTV_INIT, hold: 1'b0};

    entry_t [N_OUT-1:0]              shadow_q, shadow_d;
    entry_t [N_OUT-1:0]              active_q, active_d;
    logic   [N_OUT-1:0][W_CHAN-1:0]  data_q, data_d;
    logic   [N_OUT-1:0]              valid_q, valid_d;
    logic                            update_q;
    logic                            commit_ack_q;
    logic                            commit_c;
    logic   [N_IN-1:0][W_CHAN-1:0]   data_in_c;

    assign data_in_c = data_packed_in;
    assign commit_c  = update_in & ~update_q;

    // Shadow write; destinations outside the table match no entry and are dropped.
    always_comb begin
        shadow_d = shadow_q;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (wr_en_in && (dest_select_in == W_SEL'(k))) begin
                shadow_d[k] = '{src: src_select_in, active: active_in, hold: hold_in};
            end
        end
    end

    // Commit copies the shadow as it stood before any same-edge write.
    always_comb begin
        active_d = commit_c ? shadow_q : active_q;
    end

    // Routing uses the pre-edge active table; out-of-range sources never match.
    always_comb begin
        data_d  = data_q;
        valid_d = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (active_q[k].active) begin
                for (int unsigned i = 0; i < N_IN; i++) begin
                    if ((active_q[k].src == W_SEL'(i)) && data_valid_in[i]) begin
                        data_d[k]  = data_in_c[i];
                        valid_d[k] = 1'b1;
                    end
                end
            end else if (!active_q[k].hold) begin
                data_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shadow_q     <= {N_OUT{ENTRY_RST}};
            active_q     <= {N_OUT{ENTRY_RST}};
            data_q       <= '0;
            valid_q      <= '0;
            update_q     <= 1'b0;
            commit_ack_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            update_q     <= update_in;
            commit_ack_q <= commit_c;
        end
    end

    assign data_packed_out = data_q;
    assign data_valid_out  = valid_q;
    assign commit_ack_out  = commit_ack_q;

endmodule

// File: tb/tb_router_sync.sv
// Scoreboard bench for router_sync: a behavioural table model pushes expected
// outputs per driven cycle, which are popped and compared after the clock edge.
module tb_router_sync;

    localparam int unsigned W  = 16;
    localparam int unsigned WS = 4;
    localparam int unsigned NI = 8;
    localparam int unsigned NO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [W*NI-1:0]   din;
    logic [NI-1:0]     vin;
    logic [WS-1:0]     src, dest;
    logic              act, hold, wr, upd;
    logic [W*NO-1:0]   dout;
    logic [NO-1:0]     vout;
    logic              ack;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    router_sync #(.W_CHAN(W), .W_SEL(WS), .N_IN(NI), .N_OUT(NO), .ACTV_INIT(1'b1)) dut (
        .clk_in(clk), .rst_in(rst),
        .data_packed_in(din), .data_valid_in(vin),
        .src_select_in(src), .dest_select_in(dest),
        .active_in(act), .hold_in(hold), .wr_en_in(wr), .update_in(upd),
        .data_packed_out(dout), .data_valid_out(vout), .commit_ack_out(ack)
    );

    typedef struct {
        logic [W*NO-1:0] data;
        logic [NO-1:0]   valid;
        logic            ack;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    int unsigned  sh_src[NO], ac_src[NO];
    bit           sh_act[NO], ac_act[NO], sh_hold[NO], ac_hold[NO];
    logic [W-1:0] m_out[NO];
    logic [NO-1:0] m_val;
    bit           m_upd, m_ack;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] out_of(input int k);
        return dout[k*W +: W];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NO; k++) begin
            sh_src[k] = 0; ac_src[k] = 0;
            sh_act[k] = 1; ac_act[k] = 1;
            sh_hold[k] = 0; ac_hold[k] = 0;
            m_out[k] = '0;
        end
        m_val = '0; m_upd = 0; m_ack = 0;
    endtask

    // Advance the model with the current inputs, push expectation, clock, compare.
    task automatic step();
        exp_t e;
        bit   commit;
        if (rst) begin
            model_reset();
        end else begin
            commit = upd && !m_upd;
            m_val = '0;
            for (int k = 0; k < NO; k++) begin
                if (ac_act[k]) begin
                    if (ac_src[k] < NI && vin[ac_src[k]]) begin
                        m_out[k] = din[ac_src[k]*W +: W];
                        m_val[k] = 1'b1;
                    end
                end else if (!ac_hold[k]) begin
                    m_out[k] = '0;
                end
            end
            if (commit) begin
                for (int k = 0; k < NO; k++) begin
                    ac_src[k] = sh_src[k]; ac_act[k] = sh_act[k]; ac_hold[k] = sh_hold[k];
                end
            end
            if (wr && int'(dest) < NO) begin
                sh_src[dest] = int'(src); sh_act[dest] = act; sh_hold[dest] = hold;
            end
            m_upd = upd;
            m_ack = commit;
        end
        for (int k = 0; k < NO; k++) e.data[k*W +: W] = m_out[k];
        e.valid = m_val;
        e.ack   = m_ack;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        for (int k = 0; k < NO; k++)
            check($sformatf("sb_out%0d", k), 64'(out_of(k)), 64'(e.data[k*W +: W]));
        check("sb_valid", 64'(vout), 64'(e.valid));
        check("sb_ack", 64'(ack), 64'(e.ack));
    endtask

    task automatic wr_entry(input int d, input int s, input bit a, input bit h);
        wr = 1'b1; dest = WS'(d); src = WS'(s); act = a; hold = h;
        step();
        wr = 1'b0;
    endtask

    task automatic commit();
        upd = 1'b1; step();
        upd = 1'b0; step();
    endtask

    task automatic strobe(input int ch, input logic [W-1:0] val);
        din[ch*W +: W] = val;
        vin = NI'(1) << ch;
        step();
        vin = '0;
    endtask

    initial begin
        int acks;
        rst = 1'b1; din = '0; vin = '0; src = '0; dest = '0;
        act = 1'b0; hold = 1'b0; wr = 1'b0; upd = 1'b0;
        model_reset();
        step(); step();
        check("rst_valid", 64'(vout), 64'h0);
        check("rst_out0", 64'(out_of(0)), 64'h0);
        rst = 1'b0;

        // All outputs default to input 0
        strobe(0, 16'h1234);
        check("fanout_valid", 64'(vout), 64'hFF);
        check("fanout_out7", 64'(out_of(7)), 64'h1234);

        // Shadow write has no effect until committed
        wr_entry(3, 5, 1'b1, 1'b0);
        strobe(5, 16'hBEEF);
        check("uncommitted_out3", 64'(out_of(3)), 64'h1234);
        check("uncommitted_valid", 64'(vout), 64'h0);
        upd = 1'b1; step();
        check("ack_pulse_hi", 64'(ack), 64'h1);
        upd = 1'b0; step();
        check("ack_pulse_lo", 64'(ack), 64'h0);
        strobe(5, 16'hBEEF);
        check("committed_out3", 64'(out_of(3)), 64'hBEEF);
        check("committed_valid", 64'(vout), 64'h08);

        // Hold then zero deactivation on output 2
        wr_entry(2, 1, 1'b1, 1'b0);
        commit();
        strobe(1, 16'h0A0A);
        check("o2_capture", 64'(out_of(2)), 64'h0A0A);
        check("o2_valid", 64'(vout), 64'h04);
        wr_entry(2, 1, 1'b0, 1'b1);
        commit();
        strobe(1, 16'h5555);
        check("o2_hold", 64'(out_of(2)), 64'h0A0A);
        check("o2_hold_valid", 64'(vout), 64'h0);
        wr_entry(2, 1, 1'b0, 1'b0);
        upd = 1'b1; step();
        check("o2_commit_edge", 64'(out_of(2)), 64'h0A0A);
        upd = 1'b0; step();
        check("o2_zero", 64'(out_of(2)), 64'h0);

        // Write and commit on the same edge: write waits for the next commit
        wr = 1'b1; dest = 4'd4; src = 4'd6; act = 1'b1; hold = 1'b0; upd = 1'b1;
        step();
        wr = 1'b0; upd = 1'b0; step();
        strobe(6, 16'h6666);
        check("same_edge_out4", 64'(out_of(4)), 64'h1234);
        check("same_edge_valid", 64'(vout), 64'h0);
        commit();
        strobe(6, 16'h6666);
        check("second_commit_out4", 64'(out_of(4)), 64'h6666);
        check("second_commit_valid", 64'(vout), 64'h10);

        // Level held high commits once
        acks = 0;
        upd = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (ack) acks++;
        end
        upd = 1'b0; step();
        if (ack) acks++;
        check("level_one_ack", 64'(acks), 64'h1);

        // Invalid destination ignored, invalid source holds without strobes
        wr_entry(12, 9, 1'b1, 1'b0);
        wr_entry(7, 9, 1'b1, 1'b0);
        commit();
        for (int c = 0; c < NI; c++) din[c*W +: W] = W'(16'hC000 + c);
        vin = '1;
        step(); step();
        check("bad_src_out7", 64'(out_of(7)), 64'h1234);
        check("bad_src_valid7", 64'(vout[7]), 64'h0);
        check("bad_src_out3", 64'(out_of(3)), 64'hC005);

        // Reset mid-stream with a commit request on the reset edge
        wr_entry(0, 3, 1'b1, 1'b0);
        rst = 1'b1; upd = 1'b1;
        step();
        check("midrst_valid", 64'(vout), 64'h0);
        check("midrst_out3", 64'(out_of(3)), 64'h0);
        check("midrst_ack", 64'(ack), 64'h0);
        rst = 1'b0; upd = 1'b0;
        step();
        check("post_rst_valid", 64'(vout), 64'hFF);
        check("post_rst_out0", 64'(out_of(0)), 64'hC000);
        check("post_rst_ack", 64'(ack), 64'h0);

        // Randomised traffic against the model
        for (int c = 0; c < 400; c++) begin
            vin = NI'($urandom);
            for (int i = 0; i < NI; i++) din[i*W +: W] = W'($urandom);
            wr   = ($urandom_range(0, 3) == 0);
            dest = WS'($urandom_range(0, 15));
            src  = WS'($urandom_range(0, 15));
            act  = 1'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) upd = ~upd;
            rst  = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/router_sync.md
# router_sync

Clocked, parametrised successor to the pipeline's channel router. Routes N_IN packed ADC/PID-core data streams to N_OUT DAC/DDS output channels through a per-output source table. Additions over the previous router:
- per-channel valid strobes on inputs and outputs;
- a double-buffered (shadow/active) routing table with atomic commit;
- per-output hold-or-zero deactivation mode;
- registered outputs.

It sits between the PID core and the output preprocessor and is configured by the frontpanel controller.

## Interface
Parameters:
- W_CHAN, 16, width of each data channel
- W_SEL, 4, width of source/destination select fields; must satisfy 2^W_SEL >= max(N_IN, N_OUT)
- N_IN, 8, number of input channels
- N_OUT, 8, number of output channels
- ACTV_INIT, 1, reset value of every output's active bit

Ports:
- clk_in  input  1  system clock; all logic on the rising edge
- rst_in  input  1  synchronous, active-high reset
- data_packed_in  input  W_CHAN*N_IN  input channels; channel i at [i*W_CHAN +: W_CHAN]
- data_valid_in  input  N_IN  per-input one-cycle new-sample strobe
- src_select_in  input  W_SEL  source channel for a shadow write
- dest_select_in  input  W_SEL  destination (output) index for a shadow write
- active_in  input  1  active bit for a shadow write
- hold_in  input  1  hold mode for a shadow write: 1 = hold last value when inactive, 0 = force zero
- wr_en_in  input  1  write {src, active, hold} into shadow[dest_select_in]
- update_in  input  1  commit request; level signal, rising edge acts
- data_packed_out  output  W_CHAN*N_OUT  output channels, registered
- data_valid_out  output  N_OUT  per-output one-cycle strobe marking a new sample
- commit_ack_out  output  1  one-cycle pulse when the active table is loaded

## Operation
- Each table entry holds src (W_SEL bits), active (1 bit) and hold (1 bit). There is one shadow table and one active table, each with N_OUT entries.
- Shadow write: on a clock edge with wr_en_in=1 and dest_select_in < N_OUT, shadow[dest] <= {src_select_in, active_in, hold_in}. If dest_select_in >= N_OUT the write is ignored and no state changes.
- Commit:
  - update_in is registered into update_q.
  - On an edge where update_in=1 and update_q=0, every active entry is loaded from its shadow entry simultaneously, and commit_ack_out=1 during the following cycle.
  - A level held high does not re-commit.
- Routing for output k, on each edge, using the active table as it was before that edge:
  - If active[k]=1, src[k] < N_IN and data_valid_in[src[k]]=1: out[k] <= data_packed_in[src[k]], data_valid_out[k] <= 1.
  - If active[k]=1 and the selected input is not valid (or src[k] >= N_IN): out[k] keeps its value, data_valid_out[k] <= 0.
  - If active[k]=0 and hold[k]=1: out[k] keeps its value, data_valid_out[k] <= 0.
  - If active[k]=0 and hold[k]=0: out[k] <= 0, data_valid_out[k] <= 0.
- Fan-out: any number of outputs may select the same input; each output captures it independently.
- No arithmetic is performed; data passes bit-exact and unsigned-agnostic.

## Timing
- Reset (rst_in=1 at an edge) sets:
  - data_packed_out = 0, data_valid_out = 0, commit_ack_out = 0, update_q = 0;
  - every shadow and active entry = {src 0, active ACTV_INIT, hold 0}.
- Reset dominates wr_en_in and update_in in the same cycle. A commit pending during reset is lost.
- Data latency is 1 cycle: a sample strobed at edge t appears with data_valid_out at t+1.
- Commit timing: a rising edge of update_in sampled at edge t loads the active table at edge t. Samples captured at edge t still use the old table; samples captured at t+1 and later use the new table. commit_ack_out is high for cycle t..t+1.
- Write and commit on the same edge: the commit loads the shadow contents from before that write. The write still lands in the shadow and takes effect only at the next commit.
- Deactivation with hold=0: the output reads zero from the first edge after the commit edge.
- Throughput: one sample per output per cycle; data_valid_in may be high continuously.

## Test plan
- Reset with ACTV_INIT=1 and data_valid_in=8'h01, input 0 = 16'h1234, then strobe -> all 8 outputs read 16'h1234 with data_valid_out=8'hFF one cycle after the strobe.
- Write shadow[3] = src 5, active 1, hold 0, without committing, then strobe input 5 = 16'hBEEF -> output 3 unchanged (still src 0). Pulse update_in -> commit_ack_out is a single pulse, and the next input-5 strobe yields out[3]=16'hBEEF with only bit 3 set among outputs sourcing 5.
- Output 2 holding 16'h0A0A; commit active=0, hold=1 -> out[2] stays 16'h0A0A with no valid. Commit active=0, hold=0 -> out[2]=0 on the edge after commit.
- Assert wr_en_in and the update_in rising edge on the same edge for dest 4 -> the active entry is unchanged. A second update_in pulse applies the write. update_in held high for 10 cycles gives exactly one commit_ack_out.
- Apply src_select_in=4'd9 with N_IN=8 and dest_select_in=4'd12 with N_OUT=8 -> the invalid destination write is ignored. A committed invalid source holds its output with no valid strobes.
- Assert rst_in mid-stream while data_valid_in is continuous and a commit is pending -> all outputs are 0 and the table is reset the following cycle, with no commit_ack_out.
